// File: rtl/systolic_array_ws.sv
// Weight-stationary ROWS x COLS systolic matrix-vector engine: y[i] = sum_j W[i][j]*x[j].
// Internal weight-load sequencer, input skew / output deskew, drain-before-reload control.
//
// state   | meaning
// IDLE    | no matrix resident, waiting for cfg_load
// LOAD    | accepting weight rows 0..ROWS-1 on the w_* handshake
// COMPUTE | matrix resident, accepting activation vectors
// DRAIN   | reload requested, waiting for in-flight vectors to retire
module systolic_array_ws #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_load,
    input  logic                     w_valid,
    output logic                     w_ready,
    input  logic [COLS*DATA_W-1:0]   w_data,
    input  logic                     x_valid,
    output logic                     x_ready,
    input  logic [COLS*DATA_W-1:0]   x_data,
    output logic                     y_valid,
    output logic [ROWS*ACC_W-1:0]    y_data,
    output logic                     busy,
    output logic                     w_loaded
);
    localparam int VD = ROWS + COLS - 1;
    localparam int CW = $clog2(ROWS + COLS + 2);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int AR = (ROWS > 1) ? ROWS - 1 : 1;
    localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

    state_t                   state;
    logic [RW-1:0]            row;
    logic [CW-1:0]            inflight;
    logic [CW-1:0]            cnt_next;
    logic                     accept;
    logic                     w_acc;
    logic [VD-1:0]            vpipe;
    logic signed [DATA_W-1:0] w_q     [ROWS][COLS];
    logic signed [DATA_W-1:0] a_top   [COLS];
    logic signed [DATA_W-1:0] a_in    [ROWS][COLS];
    logic signed [DATA_W-1:0] a_q     [AR][COLS];
    logic signed [ACC_W-1:0]  p_in    [ROWS][COLS];
    logic signed [ACC_W-1:0]  p_q     [ROWS][COLS];
    logic signed [ACC_W-1:0]  row_out [ROWS];

    assign accept   = x_valid & x_ready;
    assign w_acc    = w_valid & w_ready;
    assign cnt_next = inflight + CW'(accept) - CW'(y_valid);

    // Weights are only written in LOAD, which is entered only with nothing in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            row      <= '0;
            w_ready  <= 1'b0;
            x_ready  <= 1'b0;
            busy     <= 1'b0;
            w_loaded <= 1'b0;
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    w_q[i][j] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_load) begin
                        state   <= LOAD;
                        row     <= '0;
                        w_ready <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                LOAD: begin
                    if (w_acc) begin
                        for (int j = 0; j < COLS; j++)
                            w_q[row][j] <= w_data[j*DATA_W +: DATA_W];
                        if (row == R_LAST) begin
                            state    <= COMPUTE;
                            w_ready  <= 1'b0;
                            x_ready  <= 1'b1;
                            w_loaded <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            row <= row + RW'(1);
                        end
                    end
                end
                COMPUTE: begin
                    if (cfg_load) begin
                        w_loaded <= 1'b0;
                        x_ready  <= 1'b0;
                        busy     <= 1'b1;
                        if (cnt_next == '0) begin
                            state   <= LOAD;
                            row     <= '0;
                            w_ready <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        busy <= (cnt_next != '0);
                    end
                end
                DRAIN: begin
                    if (cnt_next == '0) begin
                        state   <= LOAD;
                        row     <= '0;
                        w_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= '0;
            vpipe    <= '0;
            y_valid  <= 1'b0;
            y_data   <= '0;
        end else begin
            inflight <= cnt_next;
            vpipe[0] <= accept;
            for (int k = 1; k < VD; k++)
                vpipe[k] <= vpipe[k-1];
            y_valid <= vpipe[VD-1];
            if (vpipe[VD-1]) begin
                for (int i = 0; i < ROWS; i++)
                    y_data[i*ACC_W +: ACC_W] <= row_out[i];
            end
        end
    end

    // Column j is delayed by j registers so its activation meets the psum wavefront.
    for (genvar gj = 0; gj < COLS; gj++) begin : g_skew
        if (gj == 0) begin : g_direct
            assign a_top[gj] = x_data[gj*DATA_W +: DATA_W];
        end else begin : g_dly
            logic signed [DATA_W-1:0] sk [gj];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < gj; k++)
                        sk[k] <= '0;
                end else begin
                    sk[0] <= x_data[gj*DATA_W +: DATA_W];
                    for (int k = 1; k < gj; k++)
                        sk[k] <= sk[k-1];
                end
            end
            assign a_top[gj] = sk[gj-1];
        end
    end

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < COLS; gj++) begin : g_col
            if (gi == 0) begin : g_a0
                assign a_in[gi][gj] = a_top[gj];
            end else begin : g_an
                assign a_in[gi][gj] = a_q[gi-1][gj];
            end
            if (gj == 0) begin : g_p0
                assign p_in[gi][gj] = '0;
            end else begin : g_pn
                assign p_in[gi][gj] = p_q[gi][gj-1];
            end
        end
    end

    // Operands are sign-extended before the multiply so the add wraps modulo 2^ACC_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    p_q[i][j] <= '0;
            for (int i = 0; i < AR; i++)
                for (int j = 0; j < COLS; j++)
                    a_q[i][j] <= '0;
        end else begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    p_q[i][j] <= p_in[i][j] + ACC_W'(w_q[i][j]) * ACC_W'(a_in[i][j]);
            for (int i = 0; i < ROWS - 1; i++)
                for (int j = 0; j < COLS; j++)
                    a_q[i][j] <= a_in[i][j];
        end
    end

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_deskew
        localparam int ND = ROWS - 1 - gi;
        if (ND == 0) begin : g_direct
            assign row_out[gi] = p_q[gi][COLS-1];
        end else begin : g_dly
            logic signed [ACC_W-1:0] dq [ND];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < ND; k++)
                        dq[k] <= '0;
                end else begin
                    dq[0] <= p_q[gi][COLS-1];
                    for (int k = 1; k < ND; k++)
                        dq[k] <= dq[k-1];
                end
            end
            assign row_out[gi] = dq[ND-1];
        end
    end

endmodule
